// File: rtl/display_pkg.sv
// Shared types, constants and segment decoding for the six-digit display controller.
package display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;
  localparam int SRC_W      = NUM_DIGITS * 4;
  localparam int NUM_SRC    = 3;
  localparam int NUM_BTN    = 3;
  localparam int HEX_W      = NUM_DIGITS * SEG_W;

  // Active-low segment patterns: every segment off, and only segment g lit.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    MSG   = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Single hex nibble to active-low segments, bit 0 = a ... bit 6 = g.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nibble);
    logic [SEG_W-1:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Whole 24-bit word to the 42-bit bus; nibble d drives digit d.
  function automatic logic [HEX_W-1:0] decode_word(input logic [SRC_W-1:0] word);
    logic [HEX_W-1:0] segs;
    segs = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      segs[d*SEG_W +: SEG_W] = hex_to_seg(word[d*4 +: 4]);
    end
    return segs;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push button: 2-FF synchronizer, level debouncer and a one-cycle press pulse
// on the debounced 1->0 transition (keys are active-low).
module btn_debounce
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after it has persisted long enough.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/display_ctrl.sv
// Display controller: source scheduling, timed message override and blanking
// for the six-digit seven-segment bus.
module display_ctrl
  import display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_BTN-1:0]       buttons,
  input  logic [NUM_SRC*SRC_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic                     msg_valid,
  input  logic [SRC_W-1:0]         msg_data,
  output logic                     msg_ready,
  output logic [HEX_W-1:0]         hex_out,
  output logic [1:0]               sel_out
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [NUM_BTN-1:0] press;

  state_t             state, state_n;
  state_t             ret_state, ret_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [SRC_W-1:0]   msg_word, msg_n;
  logic [1:0]         sel, sel_n;
  logic [HEX_W-1:0]   hex_n;
  logic               handshake;
  logic [SRC_W-1:0]   cur_word;
  logic               cur_valid;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .btn   (buttons[i]),
      .press (press[i])
    );
  end

  function automatic logic [1:0] inc3(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Next valid source after cur, wrapping back to cur; plain +1 if none valid.
  function automatic logic [1:0] next_sel(input logic [1:0] cur, input logic [NUM_SRC-1:0] valid);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = inc3(cur);
    c2 = inc3(c1);
    if (valid[c1])       return c1;
    else if (valid[c2])  return c2;
    else if (valid[cur]) return cur;
    else                 return c1;
  endfunction

  // Live view of the currently selected source.
  always_comb begin
    unique case (sel)
      2'd1:    begin cur_word = src_data[1*SRC_W +: SRC_W]; cur_valid = src_valid[1]; end
      2'd2:    begin cur_word = src_data[2*SRC_W +: SRC_W]; cur_valid = src_valid[2]; end
      default: begin cur_word = src_data[0 +: SRC_W];      cur_valid = src_valid[0]; end
    endcase
  end

  assign msg_ready = (state != MSG);
  assign sel_out   = sel;

  // Next-state, hold counter, selection and the next display image.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    ret_n     = ret_state;
    hold_n    = hold_cnt;
    msg_n     = msg_word;
    sel_n     = sel;
    hex_n     = {NUM_DIGITS{SEG_BLANK}};
    handshake = msg_valid && msg_ready;

    unique case (state)
      SHOW: begin
        hex_n = cur_valid ? decode_word(cur_word) : {NUM_DIGITS{SEG_DASH}};
        if (handshake) begin
          state_n = MSG;
          ret_n   = SHOW;
          hold_n  = HOLD_LOAD;
          msg_n   = msg_data;
        end else if (press[1]) begin
          state_n = BLANK;
        end else if (press[0]) begin
          sel_n = next_sel(sel, src_valid);
        end
      end
      BLANK: begin
        if (handshake) begin
          state_n = MSG;
          ret_n   = BLANK;
          hold_n  = HOLD_LOAD;
          msg_n   = msg_data;
        end else if (press[1]) begin
          state_n = SHOW;
        end
      end
      MSG: begin
        hex_n = decode_word(msg_word);
        // Expiry and dismiss coincide harmlessly: both select the saved state.
        if (press[2] || hold_cnt == '0) begin
          state_n = ret_state;
        end else begin
          hold_n = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_n = SHOW;
    endcase
  end

  // State, context registers and the registered segment bus.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state     <= SHOW;
      ret_state <= SHOW;
      hold_cnt  <= '0;
      msg_word  <= '0;
      sel       <= 2'd0;
      hex_out   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      hold_cnt  <= hold_n;
      msg_word  <= msg_n;
      sel       <= sel_n;
      hex_out   <= hex_n;
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them when their cycle comes up.
module tb_display_ctrl;

  localparam int KIND_HEX = 0;
  localparam int KIND_SEL = 1;
  localparam int KIND_RDY = 2;

  localparam logic [41:0] H_BLANK = {6{7'h7F}};
  localparam logic [41:0] H_DASH  = {6{7'h3F}};
  localparam logic [41:0] H_SRC0  = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}; // 012345
  localparam logic [41:0] H_SRC2  = {7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03}; // 6789AB
  localparam logic [41:0] H_ABC   = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}; // ABCDEF
  localparam logic [41:0] H_ONES  = {6{7'h79}};
  localparam logic [41:0] H_TWOS  = {6{7'h24}};
  localparam logic [41:0] H_THREE = {6{7'h30}};
  localparam logic [41:0] H_FOUR  = {6{7'h19}};

  typedef struct {
    int          cyc;
    int          kind;
    logic [41:0] val;
    string       name;
  } exp_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [2:0]  buttons;
  logic [71:0] src_data;
  logic [2:0]  src_valid;
  logic        msg_valid;
  logic [23:0] msg_data;
  logic        msg_ready;
  logic [41:0] hex_out;
  logic [1:0]  sel_out;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  display_ctrl #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .buttons     (buttons),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_ready   (msg_ready),
    .hex_out     (hex_out),
    .sel_out     (sel_out)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  int          mi;
  logic [41:0] act;
  always @(negedge clk_clk) begin
    mi = 0;
    while (mi < exp_q.size()) begin
      if (exp_q[mi].cyc <= cyc) begin
        case (exp_q[mi].kind)
          KIND_SEL: act = {40'b0, sel_out};
          KIND_RDY: act = {41'b0, msg_ready};
          default:  act = hex_out;
        endcase
        check(exp_q[mi].name, act, exp_q[mi].val);
        exp_q.delete(mi);
      end else begin
        mi++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input int kind, input logic [41:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Hold key k low 8 cycles then release; press pulse lands 6 cycles after the drive.
  task automatic press_btn(input int k);
    buttons[k] = 1'b0;
    tick(8);
    buttons[k] = 1'b1;
    tick(8);
  endtask

  task automatic rot(input int from, input int to, input logic [41:0] hv, input string nm);
    expect_at(6, KIND_SEL, 42'(from), {nm, "_sel_before"});
    expect_at(7, KIND_SEL, 42'(to), {nm, "_sel_after"});
    expect_at(8, KIND_HEX, hv, {nm, "_hex"});
    press_btn(0);
  endtask

  initial begin
    reset_reset = 1'b1;
    buttons     = 3'b111;
    src_data    = '0;
    src_valid   = 3'b000;
    msg_valid   = 1'b0;
    msg_data    = '0;

    // Reset state
    tick(2);
    expect_at(0, KIND_HEX, 42'h3FF_FFFF_FFFF, "reset_hex");
    expect_at(0, KIND_SEL, 42'd0, "reset_sel");
    expect_at(0, KIND_RDY, 42'd1, "reset_rdy");
    reset_reset = 1'b0;
    src_valid   = 3'b001;
    src_data    = {24'h6789AB, 24'hFFFFFF, 24'h012345};
    expect_at(1, KIND_HEX, H_SRC0, "src0_hex");
    tick(3);

    // Source rotation over valid sources 0 and 2
    src_valid = 3'b101;
    rot(0, 2, H_SRC2, "rot1");
    rot(2, 0, H_SRC0, "rot2");
    rot(0, 2, H_SRC2, "rot3");

    // No valid source: plain increment, dashes
    src_valid = 3'b000;
    expect_at(1, KIND_HEX, H_DASH, "dash_hex");
    tick(2);
    rot(2, 0, H_DASH, "inv1");
    rot(0, 1, H_DASH, "inv2");
    rot(1, 2, H_DASH, "inv3");

    // Short glitch on the blank key is filtered
    buttons[1] = 1'b0;
    expect_at(7, KIND_HEX, H_DASH, "glitch_hex7");
    expect_at(8, KIND_HEX, H_DASH, "glitch_hex8");
    expect_at(10, KIND_HEX, H_DASH, "glitch_hex10");
    expect_at(8, KIND_RDY, 42'd1, "glitch_rdy");
    tick(3);
    buttons[1] = 1'b1;
    tick(12);

    // Held press blanks the display
    expect_at(7, KIND_HEX, H_DASH, "blank_pre");
    expect_at(8, KIND_HEX, H_BLANK, "blank_hex");
    press_btn(1);

    // Message from BLANK runs its full hold and returns to BLANK
    msg_data  = 24'hABCDEF;
    msg_valid = 1'b1;
    expect_at(0, KIND_RDY, 42'd1, "msg_rdy_pre");
    expect_at(1, KIND_RDY, 42'd0, "msg_rdy_first");
    expect_at(10, KIND_RDY, 42'd0, "msg_rdy_last");
    expect_at(11, KIND_RDY, 42'd1, "msg_rdy_back");
    expect_at(2, KIND_HEX, H_ABC, "msg_hex_first");
    expect_at(11, KIND_HEX, H_ABC, "msg_hex_last");
    expect_at(12, KIND_HEX, H_BLANK, "msg_ret_blank");
    tick(1);
    msg_valid = 1'b0;
    tick(14);

    // Back to SHOW
    expect_at(8, KIND_HEX, H_DASH, "unblank_hex");
    press_btn(1);

    // Dismiss: press[2] lands 3 cycles into the message
    buttons[2] = 1'b0;
    tick(3);
    msg_data  = 24'h111111;
    msg_valid = 1'b1;
    expect_at(3, KIND_RDY, 42'd0, "dismiss_rdy_in");
    expect_at(4, KIND_RDY, 42'd1, "dismiss_rdy_out");
    expect_at(4, KIND_HEX, H_ONES, "dismiss_hex_msg");
    expect_at(5, KIND_HEX, H_DASH, "dismiss_hex_show");
    tick(1);
    msg_valid = 1'b0;
    tick(4);
    buttons[2] = 1'b1;
    tick(10);

    // Collision: press[0] and handshake in the same cycle
    buttons[0] = 1'b0;
    expect_at(7, KIND_SEL, 42'd2, "coll_sel");
    expect_at(8, KIND_RDY, 42'd0, "coll_rdy");
    expect_at(18, KIND_SEL, 42'd2, "coll_sel_after");
    expect_at(18, KIND_RDY, 42'd1, "coll_rdy_after");
    tick(6);
    msg_data  = 24'h555555;
    msg_valid = 1'b1;
    tick(1);
    msg_valid = 1'b0;
    tick(1);
    buttons[0] = 1'b1;
    tick(14);

    // msg_valid held high through MSG: accepted again right after return
    msg_data  = 24'h333333;
    msg_valid = 1'b1;
    expect_at(1, KIND_RDY, 42'd0, "held_rdy_in");
    expect_at(2, KIND_HEX, H_THREE, "held_hex1");
    expect_at(11, KIND_RDY, 42'd1, "held_rdy_back");
    expect_at(12, KIND_RDY, 42'd0, "held_rdy_again");
    expect_at(12, KIND_HEX, H_DASH, "held_hex_gap");
    expect_at(13, KIND_HEX, H_FOUR, "held_hex2");
    tick(11);
    msg_data = 24'h444444;
    tick(1);
    msg_valid = 1'b0;
    tick(12);

    // Reset mid-message
    msg_data  = 24'h222222;
    msg_valid = 1'b1;
    expect_at(2, KIND_HEX, H_TWOS, "rstmsg_hex");
    tick(1);
    msg_valid = 1'b0;
    tick(4);
    reset_reset = 1'b1;
    expect_at(1, KIND_HEX, H_BLANK, "rstmsg_hex_rst");
    expect_at(1, KIND_SEL, 42'd0, "rstmsg_sel_rst");
    expect_at(1, KIND_RDY, 42'd1, "rstmsg_rdy_rst");
    tick(2);
    reset_reset = 1'b0;
    expect_at(1, KIND_HEX, H_DASH, "rstmsg_show1");
    expect_at(5, KIND_HEX, H_DASH, "rstmsg_show5");
    expect_at(8, KIND_HEX, H_DASH, "rstmsg_show8");
    expect_at(8, KIND_SEL, 42'd0, "rstmsg_sel");
    expect_at(8, KIND_RDY, 42'd1, "rstmsg_rdy");
    tick(10);

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) tick(1);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
